// File: rtl/kd_sort_ctrl.sv
// Sequencer for a kd-tree compare-exchange sort: walks every parent node once
// per pass, feeds an external CE element and repeats passes until clean.
module kd_sort_ctrl #(
    parameter int dim        = 3,
    parameter int data_range = 255,
    parameter int NODES      = 7,
    parameter int MAX_PASSES = 8,
    localparam int dim_size    = $clog2(data_range),
    localparam int center_size = dim * dim_size,
    localparam int axis_size   = $clog2(dim),
    localparam int IW          = $clog2(NODES),
    localparam int PW          = $clog2(MAX_PASSES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   load_valid,
    input  logic [IW-1:0]          load_idx,
    input  logic [center_size-1:0] load_data,
    output logic                   load_ready,
    input  logic [IW-1:0]          rd_idx,
    output logic [center_size-1:0] rd_data,
    output logic                   busy,
    output logic                   done,
    output logic                   converged,
    output logic [PW-1:0]          pass_count,
    output logic                   ce_en,
    output logic                   ce_sorting,
    output logic                   ce_left_en,
    output logic                   ce_right_en,
    output logic [center_size-1:0] ce_left,
    output logic [center_size-1:0] ce_parent,
    output logic [center_size-1:0] ce_right,
    output logic [axis_size-1:0]   ce_axis,
    input  logic                   ce_stable,
    input  logic                   ce_left_switch,
    input  logic                   ce_parent_switch,
    input  logic                   ce_right_switch,
    input  logic [center_size-1:0] ce_new_left,
    input  logic [center_size-1:0] ce_new_parent,
    input  logic [center_size-1:0] ce_new_right
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_CAPTURE, S_CHECK, S_DONE
    } state_t;

    localparam logic [IW+1:0] NODES_W = (IW+2)'(NODES);

    state_t                   r_state;
    logic [center_size-1:0]   r_node [NODES];
    logic [IW-1:0]            r_p;
    logic [axis_size-1:0]     r_axis;
    logic [PW-1:0]            r_pass;
    logic                     r_dirty;
    logic                     r_conv;

    logic [IW+1:0] w_p, w_l, w_r, w_nx;
    logic          w_l_en, w_r_en, w_new_lvl, w_sw;
    logic          w_ld_ok, w_rd_ok;
    logic          w_unused;

    assign w_unused  = ce_stable;
    assign w_p       = (IW+2)'(r_p);
    assign w_l       = {1'b0, r_p, 1'b1};
    assign w_r       = w_l + 1'b1;
    assign w_nx      = w_r + 1'b1;
    assign w_l_en    = w_l < NODES_W;
    assign w_r_en    = w_r < NODES_W;
    // Next node starts a new tree level when p+2 is a power of two
    assign w_new_lvl = ((w_p + 1'b1) & (w_p + 2'd2)) == '0;
    assign w_sw      = ce_parent_switch | (w_l_en & ce_left_switch)
                     | (w_r_en & ce_right_switch);
    assign w_ld_ok   = {2'b00, load_idx} < NODES_W;
    assign w_rd_ok   = {2'b00, rd_idx} < NODES_W;

    assign busy       = r_state != S_IDLE;
    assign load_ready = ~busy;
    assign done       = r_state == S_DONE;
    assign converged  = r_conv;
    assign pass_count = r_pass;
    assign rd_data    = w_rd_ok ? r_node[rd_idx] : '0;

    always_comb begin
        ce_en       = 1'b0;
        ce_sorting  = 1'b0;
        ce_left_en  = 1'b0;
        ce_right_en = 1'b0;
        ce_left     = '0;
        ce_parent   = '0;
        ce_right    = '0;
        ce_axis     = '0;
        if (r_state == S_ISSUE) begin
            ce_en       = 1'b1;
            ce_sorting  = 1'b1;
            ce_left_en  = w_l_en;
            ce_right_en = w_r_en;
            ce_parent   = r_node[r_p];
            ce_axis     = r_axis;
            if (w_l_en) ce_left  = r_node[w_l[IW-1:0]];
            if (w_r_en) ce_right = r_node[w_r[IW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_axis  <= '0;
            r_pass  <= '0;
            r_dirty <= 1'b0;
            r_conv  <= 1'b0;
            for (int i = 0; i < NODES; i++) r_node[i] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (load_valid && w_ld_ok) r_node[load_idx] <= load_data;
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_p     <= '0;
                        r_axis  <= '0;
                        r_pass  <= PW'(1);
                        r_dirty <= 1'b0;
                        r_conv  <= 1'b0;
                    end
                end
                S_ISSUE: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_node[r_p] <= ce_new_parent;
                    if (w_l_en) r_node[w_l[IW-1:0]] <= ce_new_left;
                    if (w_r_en) r_node[w_r[IW-1:0]] <= ce_new_right;
                    r_dirty <= r_dirty | w_sw;
                    if (w_nx < NODES_W) begin
                        r_p     <= r_p + 1'b1;
                        r_state <= S_ISSUE;
                        if (w_new_lvl)
                            r_axis <= (r_axis == axis_size'(dim - 1))
                                    ? '0 : r_axis + 1'b1;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_dirty && r_pass < PW'(MAX_PASSES)) begin
                        r_pass  <= r_pass + 1'b1;
                        r_p     <= '0;
                        r_axis  <= '0;
                        r_dirty <= 1'b0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_conv  <= ~r_dirty;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kd_sort_ctrl.sv
// Directed bench for kd_sort_ctrl with a latency-1 compare-exchange model.
module tb_kd_sort_ctrl;
    localparam int CW = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start, load_valid;
    logic [2:0]    load_idx, rd_idx;
    logic [CW-1:0] load_data;

    logic          load_ready, busy, done, converged;
    logic [CW-1:0] rd_data;
    logic [3:0]    pass_count;
    logic          ce_en, ce_sorting, ce_left_en, ce_right_en;
    logic [CW-1:0] ce_left, ce_parent, ce_right;
    logic [1:0]    ce_axis;

    logic          m_ls, m_ps, m_rs;
    logic [CW-1:0] m_l, m_p, m_r;

    logic          b_load_ready, b_busy, b_done, b_conv;
    logic [CW-1:0] b_rd_data;
    logic [3:0]    b_pass;
    logic          b_ce_en, b_sorting, b_left_en, b_right_en;
    logic [CW-1:0] b_left, b_parent, b_right;
    logic [1:0]    b_axis;

    kd_sort_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_idx(load_idx),
        .load_data(load_data), .load_ready(load_ready),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .done(done), .converged(converged),
        .pass_count(pass_count),
        .ce_en(ce_en), .ce_sorting(ce_sorting),
        .ce_left_en(ce_left_en), .ce_right_en(ce_right_en),
        .ce_left(ce_left), .ce_parent(ce_parent),
        .ce_right(ce_right), .ce_axis(ce_axis),
        .ce_stable(~(m_ls | m_ps | m_rs)),
        .ce_left_switch(m_ls), .ce_parent_switch(m_ps),
        .ce_right_switch(m_rs),
        .ce_new_left(m_l), .ce_new_parent(m_p), .ce_new_right(m_r)
    );

    kd_sort_ctrl #(.NODES(6)) dut6 (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_idx(load_idx),
        .load_data(load_data), .load_ready(b_load_ready),
        .rd_idx(rd_idx), .rd_data(b_rd_data),
        .busy(b_busy), .done(b_done), .converged(b_conv),
        .pass_count(b_pass),
        .ce_en(b_ce_en), .ce_sorting(b_sorting),
        .ce_left_en(b_left_en), .ce_right_en(b_right_en),
        .ce_left(b_left), .ce_parent(b_parent),
        .ce_right(b_right), .ce_axis(b_axis),
        .ce_stable(1'b1),
        .ce_left_switch(1'b0), .ce_parent_switch(1'b0),
        .ce_right_switch(1'b0),
        .ce_new_left('0), .ce_new_parent('0), .ce_new_right('0)
    );

    // CE model: mode 0 pass-through, 1 swap left/parent on first issue
    // after start, 2 pass-through but always flag a switch
    int mode = 0;
    int cnt  = 0;
    always @(posedge clk) begin
        if (start) cnt <= 0;
        else if (ce_en) cnt <= cnt + 1;
        if (ce_en) begin
            m_l <= ce_left; m_p <= ce_parent; m_r <= ce_right;
            m_ls <= 1'b0; m_ps <= 1'b0; m_rs <= 1'b0;
            if (mode == 2) m_ps <= 1'b1;
            else if (mode == 1 && cnt == 0) begin
                m_l <= ce_parent; m_p <= ce_left;
                m_ls <= 1'b1; m_ps <= 1'b1;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [CW-1:0] nv [7];

    task automatic load_all();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            load_valid = 1'b1; load_idx = 3'(i); load_data = nv[i];
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int ndone);
        cyc = 1; ndone = 0;
        while (!done && cyc < 300) begin
            @(negedge clk); cyc++;
        end
        if (done) ndone = 1;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    typedef struct {
        int mode;
        int exp_pass;
        bit exp_conv;
        int exp_cyc;
    } vec_t;
    vec_t tbl [3];

    initial begin
        int cyc, nd;
        logic [CW-1:0] e;
        tbl[0] = '{0, 1, 1'b1, 8};
        tbl[1] = '{1, 2, 1'b1, 15};
        tbl[2] = '{2, 8, 1'b0, 57};
        for (int i = 0; i < 7; i++)
            nv[i] = {8'(i + 1), 8'(3 * i + 2), 8'(5 * i + 7)};

        rst = 1'b1; start = 1'b0; load_valid = 1'b0;
        load_idx = '0; load_data = '0; rd_idx = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conv", converged, 0);
        chk("rst_pass", pass_count, 0);
        chk("rst_ce_en", ce_en, 0);
        chk("rst_load_ready", load_ready, 1);
        rd_idx = 3'd4; #1;
        chk("rst_rd4", rd_data, 0);

        for (int t = 0; t < 3; t++) begin
            mode = tbl[t].mode;
            load_all();
            pulse_start();
            wait_done(cyc, nd);
            chk("run_done_cycle", 64'(cyc), 64'(tbl[t].exp_cyc));
            chk("run_done_count", 64'(nd), 1);
            chk("run_pass", pass_count, 64'(tbl[t].exp_pass));
            chk("run_conv", converged, tbl[t].exp_conv);
            chk("run_idle", busy, 0);
            for (int i = 0; i < 7; i++) begin
                e = nv[i];
                if (mode == 1 && i == 0) e = nv[1];
                if (mode == 1 && i == 1) e = nv[0];
                rd_idx = 3'(i); #1;
                chk("run_node", rd_data, e);
            end
        end

        mode = 0;
        load_all();
        pulse_start();
        chk("c1_ce_en", ce_en, 1);
        chk("c1_sorting", ce_sorting, 1);
        chk("c1_axis", ce_axis, 0);
        chk("c1_left", ce_left, nv[1]);
        chk("c1_parent", ce_parent, nv[0]);
        chk("c1_right", ce_right, nv[2]);
        @(negedge clk);
        chk("c2_ce_en", ce_en, 0);
        chk("c2_left_zero", ce_left, 0);
        chk("c2_load_ready", load_ready, 0);
        load_valid = 1'b1; load_idx = 3'd3; load_data = 24'h0A0B0C;
        @(negedge clk);
        load_valid = 1'b0;
        chk("c3_axis", ce_axis, 1);
        chk("c3_left_busy_load", ce_left, nv[3]);
        @(negedge clk);
        @(negedge clk);
        chk("c5_axis", ce_axis, 1);
        chk("c5_left", ce_left, nv[5]);
        chk("c5_right", ce_right, nv[6]);
        chk("n6_ce_en", b_ce_en, 1);
        chk("n6_axis", b_axis, 1);
        chk("n6_left_en", b_left_en, 1);
        chk("n6_right_en", b_right_en, 0);
        chk("n6_right", b_right, 0);
        cyc = 5;
        while (busy && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        chk("trace_idle", busy, 0);
        rd_idx = 3'd3; #1;
        chk("busy_load_ignored", rd_data, nv[3]);
        @(negedge clk);
        load_valid = 1'b1; load_idx = 3'd3; load_data = 24'h0A0B0C;
        @(negedge clk);
        load_valid = 1'b0; #1;
        chk("idle_load", rd_data, 24'h0A0B0C);

        @(negedge clk);
        load_valid = 1'b1; load_idx = 3'd0; load_data = 24'h123456;
        start = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; start = 1'b0;
        chk("ld_start_parent", ce_parent, 24'h123456);
        wait_done(cyc, nd);
        chk("ld_start_cycle", 64'(cyc), 8);

        load_all();
        pulse_start();
        @(negedge clk);
        rst = 1'b1; #1;
        chk("arst_busy", busy, 0);
        chk("arst_ce_en", ce_en, 0);
        @(negedge clk);
        chk("rst_pass_cnt", pass_count, 0);
        for (int i = 0; i < 7; i++) begin
            rd_idx = 3'(i); #1;
            chk("arst_node", rd_data, 0);
        end
        rst = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("arst_no_done", 64'(nd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/kd_sort_ctrl.md
KD_SORT_CTRL -- requirements
Module: kd_sort_ctrl

Interface
REQ-001 SHALL have parameter dim, default 3, dimensions per center.
REQ-002 SHALL have parameter data_range, default 255, max per-dimension value; dim_size = clog2(data_range), center_size = dim*dim_size, axis_size = clog2(dim).
REQ-003 SHALL have parameter NODES, default 7, centers in the implicit kd-tree; children of node p are 2p+1 and 2p+2.
REQ-004 SHALL have parameter MAX_PASSES, default 8, pass limit before forced stop.
REQ-005 SHALL have one clock; reset is asynchronous and active-high:
 clk  in  1  clock
 rst  in  1  async active-high reset
 start  in  1  one-cycle pulse, begin sort
 load_valid  in  1  write center
 load_idx  in  clog2(NODES)  write index
 load_data  in  center_size  write value
 load_ready  out  1  load accepted (IDLE only)
 rd_idx  in  clog2(NODES)  read index
 rd_data  out  center_size  combinational read of node[rd_idx]
 busy  out  1  not IDLE
 done  out  1  one-cycle pulse at end of sort
 converged  out  1  last sort ended on clean pass
 pass_count  out  clog2(MAX_PASSES)+1  passes run in last/current sort
 ce_en, ce_sorting, ce_left_en, ce_right_en  out  1 each  compare-exchange element controls
 ce_left, ce_parent, ce_right  out  center_size each  operands
 ce_axis  out  axis_size  split axis
 ce_stable, ce_left_switch, ce_parent_switch, ce_right_switch  in  1 each  CE flags
 ce_new_left, ce_new_parent, ce_new_right  in  center_size each  CE results

Function
REQ-006 SHALL hold NODES center registers; load write occurs when load_valid and IDLE; out-of-range load_idx ignored.
REQ-007 SHALL implement states IDLE, ISSUE, CAPTURE, CHECK, DONE.
REQ-008 IDLE->ISSUE on start: p=0, axis=0, pass_count=1, dirty=0; start outside IDLE ignored.
REQ-009 ISSUE (1 cycle): ce_en=1, ce_sorting=1, operands node[2p+1], node[p], node[2p+2]; ce_left_en/ce_right_en=1 only if child index < NODES, absent child operand driven 0.
REQ-010 CAPTURE (1 cycle, CE latency 1): write ce_new_* back to enabled nodes only; dirty |= any switch flag of an enabled position.
REQ-011 After CAPTURE: if 2(p+1)+1 < NODES then p++, ISSUE; else CHECK. Per node exactly 2 cycles.
REQ-012 ce_axis SHALL equal floor(log2(p+1)) mod dim, wrapping dim-1 -> 0.
REQ-013 CHECK: if dirty and pass_count < MAX_PASSES: pass_count++, p=0, dirty=0, ISSUE; else DONE, converged = ~dirty.
REQ-014 DONE (1 cycle): done=1, then IDLE; converged and pass_count held until next start.
REQ-015 ce_en SHALL be 0 in every state except ISSUE; all ce_* operand outputs 0 outside ISSUE.
REQ-016 busy=1 in ISSUE, CAPTURE, CHECK, DONE; load_ready = ~busy.
REQ-017 Simultaneous start and load_valid in IDLE: load written, then sort starts on loaded value next cycle.

Reset
REQ-018 rst SHALL force IDLE, all nodes 0, p=0, pass_count=0, converged=0, done=0, busy=0, all ce_* outputs 0, asynchronously, including mid-pass; no partial write-back after reset.

Verification
REQ-019 Sorted tree (NODES=7, axis-consistent, CE model reports no switches) + start -> done 8 cycles after start (6 node + CHECK + DONE), pass_count=1, converged=1, nodes unchanged.
REQ-020 CE model swaps at node 0 in pass 1 only -> pass_count=2, converged=1, node[0]/node[1] hold swapped values, done at cycle 15.
REQ-021 CE model always switches, MAX_PASSES=8 -> pass_count=8, converged=0, done once.
REQ-022 Axis trace over one pass -> ce_axis 0,1,1 for p=0,1,2; NODES=6 -> p=2 issues ce_right_en=0, ce_right=0.
REQ-023 Load idx 3 = 24'h0A0B0C while busy -> ignored, rd_data(3) unchanged; in IDLE -> rd_data(3)=24'h0A0B0C.
REQ-024 rst asserted in CAPTURE of pass 1 -> next edge busy=0, ce_en=0, all rd_data 0, no done pulse.
